// File: rtl/halloween_prog_encoder.sv
// Packs legal (category, item) opcodes four to a 16-bit program word and offers it by valid/ready.
// Define HALLOWEEN_PROG_STATS_EN to add the words_sent / rejects saturating counters.
module halloween_prog_encoder #(
    parameter logic [3:0] PAD_OP  = 4'b0011,
    parameter int         TIMEOUT = 16,
    parameter int         TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cat,
    input  logic [1:0]  req_sel,
    input  logic        flush,
    output logic        prog_valid,
    input  logic        prog_ready,
    output logic [15:0] prog_data,
    output logic        err
`ifdef HALLOWEEN_PROG_STATS_EN
    ,
    output logic [7:0]  words_sent,
    output logic [7:0]  rejects
`endif
);

    typedef enum logic {S_FILL, S_SEND} state_t;

    localparam logic            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic            r_err;
    logic [TO_W-1:0] r_timer;

    logic [3:0] w_opcode;
    logic       w_legal;
    logic       w_hs;
    logic       w_write;
    logic [2:0] w_cnt_post;
    logic       w_idle;
    logic       w_timeout;
    logic       w_go_send;
    logic       w_prog_hs;

    assign w_opcode   = {req_cat, req_sel};
    assign w_legal    = (req_sel != 2'b11) && !((req_cat == 2'b00) && req_sel[1]);
    assign w_hs       = (r_state == S_FILL) && req_valid;
    assign w_write    = w_hs && w_legal;
    assign w_cnt_post = r_cnt + 3'(w_write);
    assign w_idle     = (r_state == S_FILL) && (r_cnt != 3'd0) && !w_hs;
    // The cycle the timer would reach TIMEOUT is itself the flush cycle.
    assign w_timeout  = TO_EN && w_idle && (r_timer == TO_LAST);
    assign w_go_send  = (r_state == S_FILL) &&
                        ((w_cnt_post == 3'd4) || ((flush || w_timeout) && (w_cnt_post != 3'd0)));
    assign w_prog_hs  = (r_state == S_SEND) && prog_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_err <= w_hs && !w_legal;
            case (r_state)
                S_FILL: begin
                    if (w_write)
                        r_cnt <= w_cnt_post;
                    if (w_go_send)
                        r_state <= S_SEND;
                    if (!TO_EN || !w_idle || w_go_send)
                        r_timer <= '0;
                    else
                        r_timer <= r_timer + 1'b1;
                end
                S_SEND: begin
                    r_timer <= '0;
                    if (prog_ready) begin
                        r_state <= S_FILL;
                        r_cnt   <= 3'd0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [3:0] r_slot;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_slot <= PAD_OP;
                else if (w_prog_hs)
                    r_slot <= PAD_OP;
                else if (w_write && (r_cnt == 3'(gi)))
                    r_slot <= w_opcode;
            end
            assign prog_data[gi*4 +: 4] = r_slot;
        end
    endgenerate

    assign req_ready  = (r_state == S_FILL);
    assign prog_valid = (r_state == S_SEND);
    assign err        = r_err;

`ifdef HALLOWEEN_PROG_STATS_EN
    logic [7:0] r_words_sent;
    logic [7:0] r_rejects;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_sent <= 8'd0;
            r_rejects    <= 8'd0;
        end else begin
            if (w_prog_hs && (r_words_sent != 8'hFF))
                r_words_sent <= r_words_sent + 8'd1;
            if (w_hs && !w_legal && (r_rejects != 8'hFF))
                r_rejects <= r_rejects + 8'd1;
        end
    end

    assign words_sent = r_words_sent;
    assign rejects    = r_rejects;
`endif

endmodule

// File: tb/tb_halloween_prog_encoder.sv
// Randomized and directed bench for halloween_prog_encoder against a queue-based program-word model.
module tb_halloween_prog_encoder;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cat = 2'b00;
    logic [1:0]  req_sel = 2'b00;
    logic        flush = 1'b0;
    logic        prog_valid;
    logic        prog_ready = 1'b0;
    logic [15:0] prog_data;
    logic        err;

    halloween_prog_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cat    (req_cat),
        .req_sel    (req_sel),
        .flush      (flush),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: opcodes of the word being built, in execution order.
    logic [3:0] cur[$];
    bit         m_valid = 1'b0;
    bit         m_err   = 1'b0;
    int         idle    = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
    endfunction

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        w = 16'h3333;
        for (int i = 0; i < cur.size(); i++)
            w[i*4 +: 4] = cur[i];
        return w;
    endfunction

    // One clock: check outputs at the falling edge, drive inputs, advance the model.
    task automatic cyc(input bit v, input logic [1:0] c, input logic [1:0] s,
                       input bit fl, input bit pr);
        int         old;
        logic [3:0] op;
        @(negedge clk);
        check_eq("prog_valid", prog_valid, m_valid);
        check_eq("req_ready", req_ready, !m_valid);
        check_eq("prog_data", prog_data, model_word());
        check_eq("err", err, m_err);
        req_valid  = v;
        req_cat    = c;
        req_sel    = s;
        flush      = fl;
        prog_ready = pr;
        if (m_valid) begin
            m_err = 1'b0;
            idle  = 0;
            if (pr) begin
                m_valid = 1'b0;
                cur.delete();
            end
        end else begin
            old   = cur.size();
            op    = {c, s};
            m_err = v && !is_legal(op);
            if (v && is_legal(op))
                cur.push_back(op);
            if (!v && old > 0) idle++;
            else               idle = 0;
            if (cur.size() == 4 ||
                ((fl || (TIMEOUT > 0 && idle >= TIMEOUT)) && cur.size() > 0)) begin
                m_valid = 1'b1;
                idle    = 0;
            end
        end
    endtask

    task automatic idle_cyc(input bit pr);
        cyc(1'b0, 2'b00, 2'b00, 1'b0, pr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid", prog_valid, 16'd0);
        check_eq("rst_ready", req_ready, 16'd1);
        check_eq("rst_err", err, 16'd0);
        check_eq("rst_data", prog_data, 16'h3333);
        cur.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        idle    = 0;
        req_valid = 1'b0; flush = 1'b0; prog_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("init_data", prog_data, 16'h3333);
        check_eq("init_valid", prog_valid, 16'd0);
        rst = 1'b0;

        // Full word GRN, BOO, JAW, FOG
        cyc(1, 2'b01, 2'b00, 0, 1);
        cyc(1, 2'b10, 2'b10, 0, 1);
        cyc(1, 2'b11, 2'b01, 0, 1);
        cyc(1, 2'b11, 2'b10, 0, 0);
        idle_cyc(0);
        check_eq("full_word", prog_data, 16'hEDA4);
        check_eq("full_valid", prog_valid, 16'd1);
        idle_cyc(1);
        idle_cyc(1);

        // Flush partial PUR, WAVE; then flush on empty buffer
        cyc(1, 2'b01, 2'b01, 0, 0);
        cyc(1, 2'b11, 2'b00, 0, 0);
        cyc(0, 2'b00, 2'b00, 1, 0);
        idle_cyc(0);
        check_eq("flush_word", prog_data, 16'h33C5);
        idle_cyc(1);
        cyc(0, 2'b00, 2'b00, 1, 1);
        idle_cyc(1);
        check_eq("empty_flush", prog_valid, 16'd0);

        // Illegal requests
        cyc(1, 2'b00, 2'b10, 0, 1);
        cyc(1, 2'b01, 2'b11, 0, 1);
        idle_cyc(1);
        check_eq("illegal_err", err, 16'd1);
        idle_cyc(1);

        // Timeout with backpressure: ORG then idle
        cyc(1, 2'b01, 2'b10, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) idle_cyc(0);
        idle_cyc(0);
        check_eq("to_valid", prog_valid, 16'd1);
        check_eq("to_word", prog_data, 16'h3336);
        for (int i = 0; i < 10; i++) cyc(1, 2'b01, 2'b00, 1, 0);
        check_eq("bp_word", prog_data, 16'h3336);
        idle_cyc(1);
        idle_cyc(1);

        // Three stored, fourth together with flush
        cyc(1, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b10, 2'b01, 0, 0);
        cyc(1, 2'b11, 2'b00, 0, 0);
        cyc(1, 2'b01, 2'b01, 1, 0);
        idle_cyc(0);
        check_eq("simul_word", prog_data, 16'h5C90);
        idle_cyc(1);

        // Reset in the middle of a partial word
        cyc(1, 2'b10, 2'b00, 0, 0);
        do_reset();

        // Random traffic, dense then sparse so timeouts also occur
        for (int i = 0; i < 600; i++) begin
            bit v;
            v = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            cyc(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            if (i == 250) do_reset();
        end
        idle_cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
